// File: rtl/ysyx_22040383_mem_stage.sv
// MEM stage: issues loads/stores on a valid/ready data-memory bus, aligns and extends load data,
// and registers the writeback payload toward MEM/WB while stalling upstream during an access.
module ysyx_22040383_mem_stage #(
  parameter int XLEN = 64
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic            mempr_mem_valid,
  input  logic            mempr_mem_is_read_dmem,
  input  logic            mempr_mem_is_write_dmem,
  input  logic            mempr_mem_load_unsigned,
  input  logic [7:0]      mempr_mem_write_width,
  input  logic [1:0]      mempr_mem_wb_select,
  input  logic [XLEN-1:0] mempr_mem_alu_res,
  input  logic [XLEN-1:0] mempr_mem_rs2_data,
  input  logic [XLEN-1:0] mempr_mem_pc_plus_4,
  input  logic [4:0]      mempr_mem_rd,
  input  logic            mempr_mem_is_write_rf,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_req_addr,
  output logic            dmem_req_wen,
  output logic [XLEN-1:0] dmem_req_wdata,
  output logic [7:0]      dmem_req_wstrb,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rsp_rdata,
  output logic            mem_stall,
  output logic            mem_wbpr_valid,
  output logic [XLEN-1:0] mem_wbpr_wb_data,
  output logic [4:0]      mem_wbpr_rd,
  output logic            mem_wbpr_is_write_rf,
  output logic            mem_wbpr_misalign
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2} state_e;

  function automatic logic width_legal(input logic [7:0] w);
    case (w)
      8'h01, 8'h03, 8'h0F, 8'hFF: width_legal = 1'b1;
      default:                    width_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_align(input logic [XLEN-1:0] rdata, input logic [2:0] off,
                                                 input logic [7:0] w, input logic uns);
    logic [XLEN-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (w)
      8'h01:   load_align = {{(XLEN-8){~uns & sh[7]}}, sh[7:0]};
      8'h03:   load_align = {{(XLEN-16){~uns & sh[15]}}, sh[15:0]};
      8'h0F:   load_align = {{(XLEN-32){~uns & sh[31]}}, sh[31:0]};
      default: load_align = sh;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] wb_mux(input logic [1:0] sel, input logic [XLEN-1:0] alu,
                                             input logic [XLEN-1:0] ld, input logic [XLEN-1:0] pc4);
    case (sel)
      2'b01:   wb_mux = ld;
      2'b10:   wb_mux = pc4;
      default: wb_mux = alu;
    endcase
  endfunction

  state_e          state_q, state_d;
  logic [XLEN-1:0] alu_q, alu_d, wdata_q, wdata_d, pc4_q, pc4_d;
  logic [7:0]      wstrb_q, wstrb_d, width_q, width_d;
  logic            wen_q, wen_d, is_read_q, is_read_d, uns_q, uns_d, wrf_q, wrf_d;
  logic [1:0]      wb_sel_q, wb_sel_d;
  logic [4:0]      rd_q, rd_d, wbpr_rd_q, wbpr_rd_d;
  logic            wbpr_valid_q, wbpr_valid_d, wbpr_wrf_q, wbpr_wrf_d, misalign_q, misalign_d;
  logic [XLEN-1:0] wb_data_q, wb_data_d;
  logic            mem_op, acc_err;
  logic [XLEN-1:0] load_data;

  // The low-offset mask {w[4],w[2],w[1]} is (bytes-1) for every legal width.
  assign mem_op    = mempr_mem_valid & (mempr_mem_is_read_dmem | mempr_mem_is_write_dmem);
  assign acc_err   = mem_op & ((mempr_mem_is_read_dmem & mempr_mem_is_write_dmem)
                     | ~width_legal(mempr_mem_write_width)
                     | (|(mempr_mem_alu_res[2:0] & {mempr_mem_write_width[4], mempr_mem_write_width[2],
                                                    mempr_mem_write_width[1]})));
  assign load_data = load_align(dmem_rsp_rdata, alu_q[2:0], width_q, uns_q);

  assign dmem_req_valid       = (state_q == ST_REQ);
  assign dmem_req_addr        = {alu_q[XLEN-1:3], 3'b000};
  assign dmem_req_wen         = wen_q;
  assign dmem_req_wdata       = wdata_q;
  assign dmem_req_wstrb       = wstrb_q;
  assign mem_wbpr_valid       = wbpr_valid_q;
  assign mem_wbpr_wb_data     = wb_data_q;
  assign mem_wbpr_rd          = wbpr_rd_q;
  assign mem_wbpr_is_write_rf = wbpr_wrf_q;
  assign mem_wbpr_misalign    = misalign_q;

  // Upstream stall: held for the whole access, released in the response cycle.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      ST_IDLE: mem_stall = mem_op & ~acc_err;
      ST_REQ:  mem_stall = 1'b1;
      ST_WAIT: mem_stall = ~dmem_rsp_valid;
      default: mem_stall = 1'b0;
    endcase
  end

  // Next-state and next-payload logic for the access FSM and the MEM/WB register.
  always_comb begin
    state_d      = state_q;
    alu_d        = alu_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    wen_d        = wen_q;
    is_read_d    = is_read_q;
    width_d      = width_q;
    uns_d        = uns_q;
    wb_sel_d     = wb_sel_q;
    pc4_d        = pc4_q;
    rd_d         = rd_q;
    wrf_d        = wrf_q;
    wbpr_valid_d = 1'b0;
    wb_data_d    = wb_data_q;
    wbpr_rd_d    = wbpr_rd_q;
    wbpr_wrf_d   = wbpr_wrf_q;
    misalign_d   = misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (acc_err) begin
          wbpr_valid_d = 1'b1;
          misalign_d   = 1'b1;
          wbpr_wrf_d   = 1'b0;
          wb_data_d    = {XLEN{1'b0}};
          wbpr_rd_d    = mempr_mem_rd;
        end else if (mem_op) begin
          state_d   = ST_REQ;
          alu_d     = mempr_mem_alu_res;
          wdata_d   = mempr_mem_rs2_data << {mempr_mem_alu_res[2:0], 3'b000};
          wstrb_d   = mempr_mem_write_width << mempr_mem_alu_res[2:0];
          wen_d     = mempr_mem_is_write_dmem;
          is_read_d = mempr_mem_is_read_dmem;
          width_d   = mempr_mem_write_width;
          uns_d     = mempr_mem_load_unsigned;
          wb_sel_d  = mempr_mem_wb_select;
          pc4_d     = mempr_mem_pc_plus_4;
          rd_d      = mempr_mem_rd;
          wrf_d     = mempr_mem_is_write_rf;
        end else if (mempr_mem_valid) begin
          wbpr_valid_d = 1'b1;
          misalign_d   = 1'b0;
          wbpr_wrf_d   = mempr_mem_is_write_rf;
          wb_data_d    = wb_mux(mempr_mem_wb_select, mempr_mem_alu_res, {XLEN{1'b0}}, mempr_mem_pc_plus_4);
          wbpr_rd_d    = mempr_mem_rd;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (dmem_req_ready) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (dmem_rsp_valid) begin
          state_d      = ST_IDLE;
          wbpr_valid_d = 1'b1;
          misalign_d   = 1'b0;
          wbpr_wrf_d   = wrf_q;
          wbpr_rd_d    = rd_q;
          wb_data_d    = is_read_q ? wb_mux(wb_sel_q, alu_q, load_data, pc4_q) : alu_q;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and payload registers; reset abandons any access in flight.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q      <= ST_IDLE;
      alu_q        <= {XLEN{1'b0}};
      wdata_q      <= {XLEN{1'b0}};
      wstrb_q      <= 8'h00;
      wen_q        <= 1'b0;
      is_read_q    <= 1'b0;
      width_q      <= 8'h00;
      uns_q        <= 1'b0;
      wb_sel_q     <= 2'b00;
      pc4_q        <= {XLEN{1'b0}};
      rd_q         <= 5'd0;
      wrf_q        <= 1'b0;
      wbpr_valid_q <= 1'b0;
      wb_data_q    <= {XLEN{1'b0}};
      wbpr_rd_q    <= 5'd0;
      wbpr_wrf_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_q        <= alu_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      wen_q        <= wen_d;
      is_read_q    <= is_read_d;
      width_q      <= width_d;
      uns_q        <= uns_d;
      wb_sel_q     <= wb_sel_d;
      pc4_q        <= pc4_d;
      rd_q         <= rd_d;
      wrf_q        <= wrf_d;
      wbpr_valid_q <= wbpr_valid_d;
      wb_data_q    <= wb_data_d;
      wbpr_rd_q    <= wbpr_rd_d;
      wbpr_wrf_q   <= wbpr_wrf_d;
      misalign_q   <= misalign_d;
    end
  end

endmodule
